// File: rtl/kf_loop_sequencer_pkg.sv
// Shared opcodes, FSM states and instruction field offsets
// for the Kalman filter loop sequencer.
package kf_loop_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NEXT = 2'b00,
        OP_WAIT = 2'b01,
        OP_LOOP = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        WAIT  = 2'b11
    } state_e;

    // Word layout, LSB first: F, E, D[1:0], C[1:0], B, A
    localparam int F_BIT = 0;
    localparam int E_BIT = 1;
    localparam int D_LSB = 2;
    localparam int C_LSB = 4;
    localparam int B_LSB = 6;

    function automatic int a_lsb(input int addrw);
        return B_LSB + addrw;
    endfunction

endpackage

// File: rtl/kf_loop_sequencer_if.sv
// Control-field bus towards routers/bank/AU plus the
// program-load port of the sequencer.
interface kf_loop_sequencer_if #(
    parameter int ADDRW = 5,
    parameter int PC_W  = 8
);
    localparam int IW = 2 * ADDRW + 6;

    logic             ctl_valid;
    logic [ADDRW-1:0] ctl_a;
    logic [ADDRW-1:0] ctl_b;
    logic [1:0]       ctl_c;
    logic [1:0]       ctl_d;
    logic             ctl_e;
    logic             ctl_f;

    logic             rom_we;
    logic [PC_W-1:0]  rom_waddr;
    logic [IW-1:0]    rom_wdata;

    modport master (
        output ctl_valid, ctl_a, ctl_b, ctl_c,
        output ctl_d, ctl_e, ctl_f,
        input  rom_we, rom_waddr, rom_wdata
    );

    modport slave (
        input  ctl_valid, ctl_a, ctl_b, ctl_c,
        input  ctl_d, ctl_e, ctl_f,
        output rom_we, rom_waddr, rom_wdata
    );

endinterface

// File: rtl/kf_prog_ram.sv
// Program store: one write port, one registered read port.
// Contents survive reset.
module kf_prog_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/kf_loop_sequencer.sv
// Program sequencer: PC, iteration counter, counted back-branch,
// AU wait, halt/abort and PC-overflow error.
module kf_loop_sequencer
    import kf_loop_sequencer_pkg::*;
#(
    parameter int ADDRW = 5,
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] iter_count,
    input  logic             au_done,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_left,
    output logic [PC_W-1:0]  pc_dbg,
    kf_loop_sequencer_if.master bus
);

    localparam int IW = 2 * ADDRW + 6;
    localparam int AL = a_lsb(ADDRW);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             cv_q, cv_d;
    logic [IW-1:0]    word_q, word_d;

    logic [IW-1:0]    rdata;
    logic             ram_we;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  tgt;
    logic             last;
    op_e              op;

    // Read address follows pc_d so the word is ready in FETCH
    // and can be captured into the output register at EXEC.
    assign ram_we = bus.rom_we && (state_q == IDLE);

    kf_prog_ram #(
        .AW (PC_W),
        .DW (IW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.rom_waddr),
        .wdata (bus.rom_wdata),
        .raddr (pc_d),
        .rdata (rdata)
    );

    assign pc_inc = pc_q + 1'b1;
    assign last   = (pc_q == {PC_W{1'b1}});
    assign tgt    = word_q[B_LSB +: PC_W];
    assign op     = op_e'(word_q[C_LSB +: 2]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cv_d    = 1'b0;
        word_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (start && !bus.rom_we && !abort) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    iter_d  = (iter_count == '0) ?
                              CNT_W'(1) : iter_count;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = EXEC;
                    cv_d    = 1'b1;
                    word_d  = rdata;
                end
            end
            EXEC: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (op == OP_HALT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (op == OP_LOOP && iter_q > CNT_W'(1)) begin
                    state_d = FETCH;
                    iter_d  = iter_q - 1'b1;
                    pc_d    = tgt;
                end else begin
                    if (op == OP_LOOP) begin
                        iter_d = '0;
                    end
                    if (last) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = (op == OP_WAIT) ? WAIT : FETCH;
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (au_done) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cv_q    <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cv_q    <= cv_d;
            word_q  <= word_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = !ready;
    assign done      = done_q;
    assign err       = err_q;
    assign iter_left = iter_q;
    assign pc_dbg    = pc_q;

    assign bus.ctl_valid = cv_q;
    assign bus.ctl_f     = word_q[F_BIT];
    assign bus.ctl_e     = word_q[E_BIT];
    assign bus.ctl_d     = word_q[D_LSB +: 2];
    assign bus.ctl_c     = word_q[C_LSB +: 2];
    assign bus.ctl_b     = word_q[B_LSB +: ADDRW];
    assign bus.ctl_a     = word_q[AL +: ADDRW];

endmodule

// File: tb/tb_kf_loop_sequencer.sv
// Bench for kf_loop_sequencer: directed programs plus random
// programs checked against an instruction-level reference model.
module tb_kf_loop_sequencer;
    import kf_loop_sequencer_pkg::*;

    localparam int ADDRW = 5;
    localparam int PC_W  = 3;
    localparam int CNT_W = 16;
    localparam int IW    = 2 * ADDRW + 6;
    localparam int DEPTH = 2 ** PC_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] iter_count = '0;
    logic             au_done = 1'b0;
    logic             ready, busy, done, err;
    logic [CNT_W-1:0] iter_left;
    logic [PC_W-1:0]  pc_dbg;

    kf_loop_sequencer_if #(.ADDRW(ADDRW), .PC_W(PC_W)) bus_if ();

    kf_loop_sequencer #(
        .ADDRW (ADDRW),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .iter_count (iter_count),
        .au_done    (au_done),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .iter_left  (iter_left),
        .pc_dbg     (pc_dbg),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [IW-1:0] prog [DEPTH];

    function automatic logic [IW-1:0] mk(input logic [1:0] op,
        input logic [4:0] a, input logic [4:0] b,
        input logic [1:0] d, input logic e, input logic f);
        return {a, b, op, d, e, f};
    endfunction

    // Reference model: expected strobe trace of one run
    int            q_pc[$];
    int            q_cyc[$];
    int            q_it[$];
    logic [IW-1:0] q_w[$];
    int m_end, m_done, m_err, m_iter, m_pc;

    task automatic model(input int n, input int lat);
        int pc, it, cyc, guard;
        logic [IW-1:0] w;
        logic [1:0] c;
        logic [2*ADDRW-1:0] ab;
        q_pc.delete(); q_cyc.delete(); q_it.delete(); q_w.delete();
        pc = 0;
        it = (n == 0) ? 1 : n;
        cyc = 2;
        guard = 0;
        while (guard < 2000) begin
            guard++;
            w = prog[pc];
            c = w[5:4];
            q_pc.push_back(pc); q_cyc.push_back(cyc);
            q_it.push_back(it); q_w.push_back(w);
            if (c == 2'b11) begin
                m_done = 1; m_err = 0;
                break;
            end
            if (c == 2'b10 && it > 1) begin
                it = it - 1;
                ab = w[IW-1:6];
                pc = int'(ab) % DEPTH;
                cyc += 2;
                continue;
            end
            if (c == 2'b10) it = 0;
            if (pc == DEPTH - 1) begin
                m_done = 0; m_err = 1;
                break;
            end
            pc++;
            cyc += (c == 2'b01) ? lat + 2 : 2;
        end
        m_end = cyc + 1;
        m_iter = it;
        m_pc = pc;
    endtask

    int obs_strobes, obs_pc2;

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus_if.rom_we = 1'b1;
            bus_if.rom_waddr = PC_W'(i);
            bus_if.rom_wdata = prog[i];
        end
        @(negedge clk);
        bus_if.rom_we = 1'b0;
    endtask

    task automatic do_run(input int n, input int lat, input int abort_at,
                          input int wr_at);
        int t, au_cyc, e_end, e_done, e_err, ecyc;
        bit aborted, seen_done;
        logic [IW-1:0] fields;
        model(n, lat);
        e_end = m_end; e_done = m_done; e_err = m_err;
        aborted = 0;
        if (abort_at > 0 && abort_at < m_end) begin
            aborted = 1;
            while (q_cyc.size() > 0 && q_cyc[$] > abort_at) begin
                void'(q_cyc.pop_back()); void'(q_pc.pop_back());
                void'(q_it.pop_back()); void'(q_w.pop_back());
            end
            e_end = abort_at + 1; e_done = 0; e_err = 0;
        end
        obs_strobes = 0; obs_pc2 = 0;
        au_cyc = -1; seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        iter_count = CNT_W'(n);
        t = 0;
        while (1) begin
            @(negedge clk);
            t++;
            start = 1'b0;
            abort = (t == abort_at);
            au_done = (t == au_cyc);
            bus_if.rom_we = 1'b0;
            if (t == wr_at && busy) begin
                bus_if.rom_we = 1'b1;
                bus_if.rom_waddr = PC_W'($urandom_range(0, DEPTH - 1));
                bus_if.rom_wdata = IW'($urandom);
            end
            if (t == 1) check("err_clear", err, 0);
            fields = {bus_if.ctl_a, bus_if.ctl_b, bus_if.ctl_c,
                      bus_if.ctl_d, bus_if.ctl_e, bus_if.ctl_f};
            if (bus_if.ctl_valid) begin
                obs_strobes++;
                if (pc_dbg == 2) obs_pc2++;
                if (q_pc.size() == 0) begin
                    check("extra_strobe", t, 0);
                end else begin
                    ecyc = q_cyc.pop_front();
                    check("strobe_cyc", t, ecyc);
                    check("strobe_pc", pc_dbg, q_pc.pop_front());
                    check("strobe_iter", iter_left, q_it.pop_front());
                    check("strobe_word", fields, q_w.pop_front());
                end
                if (bus_if.ctl_e) au_cyc = t + lat;
            end else begin
                check("ctl_zero", fields, 0);
            end
            if (done) seen_done = 1;
            if (ready) break;
            if (t > 1500) begin
                check("timeout", t, 0);
                break;
            end
        end
        abort = 1'b0; au_done = 1'b0; bus_if.rom_we = 1'b0;
        check("end_cyc", t, e_end);
        check("done", seen_done, e_done);
        check("err", err, e_err);
        check("missing", q_pc.size(), 0);
        if (!aborted) begin
            check("iter_end", iter_left, m_iter);
            check("pc_end", pc_dbg, m_pc);
        end
        @(negedge clk);
        check("done_low", done, 0);
        check("idle_ready", ready, 1);
    endtask

    task automatic rand_prog();
        int r;
        logic [1:0] op;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 :
                 (r < 9) ? 2'b10 : 2'b11;
            prog[i] = mk(op, 5'($urandom), 5'($urandom),
                         2'($urandom), op == 2'b01, 1'($urandom));
        end
    endtask

    initial begin
        bus_if.rom_we = 1'b0;
        bus_if.rom_waddr = '0;
        bus_if.rom_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", bus_if.ctl_valid, 0);
        check("rst_pc", pc_dbg, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_iter", iter_left, 0);

        // straight line
        for (int i = 0; i < DEPTH; i++) prog[i] = mk(2'b11, 0, 0, 0, 0, 0);
        prog[0] = mk(2'b00, 5'd3, 5'd4, 2'd1, 1'b0, 1'b1);
        prog[1] = mk(2'b00, 5'd7, 5'd9, 2'd2, 1'b0, 1'b0);
        prog[2] = mk(2'b11, 5'd1, 5'd2, 2'd3, 1'b0, 1'b1);
        load_prog();
        do_run(1, 5, -1, -1);
        check("sl_strobes", obs_strobes, 3);

        // counted loop, then iter_count 0
        prog[0] = mk(2'b00, 5'd1, 5'd2, 2'd0, 1'b0, 1'b0);
        prog[1] = mk(2'b01, 5'd4, 5'd5, 2'd1, 1'b1, 1'b0);
        prog[2] = mk(2'b10, 5'd0, 5'd0, 2'd2, 1'b0, 1'b1);
        prog[3] = mk(2'b11, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        load_prog();
        do_run(3, 5, -1, -1);
        check("loop_x3", obs_pc2, 3);
        check("loop_iter0", iter_left, 0);
        do_run(0, 5, -1, -1);
        check("loop_x1", obs_pc2, 1);

        // abort while waiting on the AU
        do_run(3, 8, 7, -1);
        check("abort_strobes", obs_strobes, 2);

        // overflow, then a run that clears err
        for (int i = 0; i < DEPTH; i++)
            prog[i] = mk(2'b00, 5'(i), 5'(i), 2'd0, 1'b0, 1'b0);
        load_prog();
        do_run(1, 3, -1, -1);
        check("ovf_strobes", obs_strobes, 8);
        check("ovf_err", err, 1);
        prog[0] = mk(2'b11, 5'd2, 5'd2, 2'd0, 1'b0, 1'b0);
        load_prog();
        do_run(1, 3, -1, -1);

        // start with rom_we: write lands, start ignored
        @(negedge clk);
        start = 1'b1;
        bus_if.rom_we = 1'b1;
        bus_if.rom_waddr = 3'd0;
        bus_if.rom_wdata = mk(2'b00, 5'd6, 5'd6, 2'd1, 1'b0, 1'b1);
        prog[0] = bus_if.rom_wdata;
        @(negedge clk);
        start = 1'b0;
        bus_if.rom_we = 1'b0;
        check("st_we_busy", busy, 0);
        @(negedge clk);
        check("st_we_valid", bus_if.ctl_valid, 0);
        prog[1] = mk(2'b11, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus_if.rom_we = 1'b1;
        bus_if.rom_waddr = 3'd1;
        bus_if.rom_wdata = prog[1];
        @(negedge clk);
        bus_if.rom_we = 1'b0;
        do_run(2, 3, -1, 3);
        do_run(2, 3, -1, 3);

        // reset mid-run keeps the program
        @(negedge clk);
        start = 1'b1;
        iter_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", bus_if.ctl_valid, 0);
        check("mid_rst_pc", pc_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
        do_run(1, 3, -1, -1);

        // randomized programs
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) begin
                rand_prog();
                load_prog();
            end
            do_run($urandom_range(0, 4), $urandom_range(1, 6),
                   ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(1, 30)) : -1,
                   $urandom_range(1, 6));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
